alu_share_arb: RTL

- Shares the single-cycle integer ALU between two requesters: port 0 is the pipeline EX stage, port 1 is the address/branch-target helper.
- Arbitrates between the requesters and registers the winner's operands into the ALU input ports.
- Captures ALUResult/Zero into a per-requester response register held until acknowledged.
- One operation in flight; valid/ready handshakes on both request and response sides.

---
 rtl/alu_share_arb.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_share_arb.sv
// alu_share_arb: shares one single-cycle ALU between the EX stage (port 0) and the
// address/branch helper (port 1). Define ALU_ARB_FIXED_PRIO_EN for fixed priority to port 0.
module alu_share_arb #(
  parameter int DATA_WIDTH     = 32,
  parameter int ALU_CTRL_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      Req0Valid,
  output logic                      Req0Ready,
  input  logic [DATA_WIDTH-1:0]     Req0SrcA,
  input  logic [DATA_WIDTH-1:0]     Req0SrcB,
  input  logic [ALU_CTRL_WIDTH-1:0] Req0Ctrl,
  input  logic [DATA_WIDTH-1:0]     Req0PC,
  input  logic                      Req1Valid,
  output logic                      Req1Ready,
  input  logic [DATA_WIDTH-1:0]     Req1SrcA,
  input  logic [DATA_WIDTH-1:0]     Req1SrcB,
  input  logic [ALU_CTRL_WIDTH-1:0] Req1Ctrl,
  input  logic [DATA_WIDTH-1:0]     Req1PC,
  output logic                      Rsp0Valid,
  input  logic                      Rsp0Ready,
  output logic                      Rsp1Valid,
  input  logic                      Rsp1Ready,
  output logic [DATA_WIDTH-1:0]     RspResult,
  output logic                      RspZero,
  output logic [DATA_WIDTH-1:0]     SrcA,
  output logic [DATA_WIDTH-1:0]     SrcB,
  output logic [DATA_WIDTH-1:0]     PC,
  output logic [ALU_CTRL_WIDTH-1:0] ALUControl,
  input  logic [DATA_WIDTH-1:0]     ALUResult,
  input  logic                      Zero
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                    state_r;
  state_t                    state_s;
  logic                      owner_r;
`ifndef ALU_ARB_FIXED_PRIO_EN
  logic                      last_r;
`endif
  logic                      grant_any_s;
  logic                      grant_sel_s;
  logic                      handshake_s;
  logic                      rsp_take_s;
  logic [DATA_WIDTH-1:0]     sel_src_a_s;
  logic [DATA_WIDTH-1:0]     sel_src_b_s;
  logic [DATA_WIDTH-1:0]     sel_pc_s;
  logic [ALU_CTRL_WIDTH-1:0] sel_ctrl_s;
  logic [DATA_WIDTH-1:0]     src_a_r;
  logic [DATA_WIDTH-1:0]     src_b_r;
  logic [DATA_WIDTH-1:0]     pc_r;
  logic [ALU_CTRL_WIDTH-1:0] ctrl_r;
  logic [DATA_WIDTH-1:0]     rsp_result_r;
  logic                      rsp_zero_r;
  logic                      rsp0_valid_r;
  logic                      rsp1_valid_r;

  // Grant selection: a lone requester wins; contention resolved by priority mode.
  always_comb begin
    grant_any_s = 1'b0;
    grant_sel_s = 1'b0;
    if (Req0Valid && Req1Valid) begin
      grant_any_s = 1'b1;
`ifdef ALU_ARB_FIXED_PRIO_EN
      grant_sel_s = 1'b0;
`else
      grant_sel_s = ~last_r;
`endif
    end else if (Req0Valid) begin
      grant_any_s = 1'b1;
      grant_sel_s = 1'b0;
    end else if (Req1Valid) begin
      grant_any_s = 1'b1;
      grant_sel_s = 1'b1;
    end else begin
      grant_any_s = 1'b0;
      grant_sel_s = 1'b0;
    end
  end

  // Request acceptance and response consumption strobes.
  always_comb begin
    handshake_s = 1'b0;
    Req0Ready   = 1'b0;
    Req1Ready   = 1'b0;
    rsp_take_s  = 1'b0;
    if ((state_r == ST_IDLE) && !rst && grant_any_s) begin
      handshake_s = 1'b1;
      Req0Ready   = ~grant_sel_s;
      Req1Ready   = grant_sel_s;
    end else begin
      handshake_s = 1'b0;
    end
    if (state_r == ST_RESP) begin
      rsp_take_s = owner_r ? Rsp1Ready : Rsp0Ready;
    end else begin
      rsp_take_s = 1'b0;
    end
  end

  // Operand mux feeding the ALU drive registers.
  always_comb begin
    sel_src_a_s = Req0SrcA;
    sel_src_b_s = Req0SrcB;
    sel_pc_s    = Req0PC;
    sel_ctrl_s  = Req0Ctrl;
    if (grant_sel_s) begin
      sel_src_a_s = Req1SrcA;
      sel_src_b_s = Req1SrcB;
      sel_pc_s    = Req1PC;
      sel_ctrl_s  = Req1Ctrl;
    end else begin
      sel_src_a_s = Req0SrcA;
      sel_src_b_s = Req0SrcB;
      sel_pc_s    = Req0PC;
      sel_ctrl_s  = Req0Ctrl;
    end
  end

  // Next-state logic: EXEC always lasts exactly one cycle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (handshake_s) state_s = ST_EXEC;
        else             state_s = ST_IDLE;
      end
      ST_EXEC: state_s = ST_RESP;
      ST_RESP: begin
        if (rsp_take_s) state_s = ST_IDLE;
        else            state_s = ST_RESP;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State, operand, and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      owner_r      <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_r       <= 1'b1;
`endif
      src_a_r      <= {DATA_WIDTH{1'b0}};
      src_b_r      <= {DATA_WIDTH{1'b0}};
      pc_r         <= {DATA_WIDTH{1'b0}};
      ctrl_r       <= {ALU_CTRL_WIDTH{1'b0}};
      rsp_result_r <= {DATA_WIDTH{1'b0}};
      rsp_zero_r   <= 1'b0;
      rsp0_valid_r <= 1'b0;
      rsp1_valid_r <= 1'b0;
    end else begin
      state_r <= state_s;
      case (state_r)
        ST_IDLE: begin
          if (handshake_s) begin
            src_a_r <= sel_src_a_s;
            src_b_r <= sel_src_b_s;
            pc_r    <= sel_pc_s;
            ctrl_r  <= sel_ctrl_s;
            owner_r <= grant_sel_s;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_r  <= grant_sel_s;
`endif
          end
        end
        ST_EXEC: begin
          rsp_result_r <= ALUResult;
          rsp_zero_r   <= Zero;
          rsp0_valid_r <= ~owner_r;
          rsp1_valid_r <= owner_r;
        end
        ST_RESP: begin
          if (rsp_take_s) begin
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
          end
        end
        default: begin
          rsp0_valid_r <= 1'b0;
          rsp1_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign SrcA       = src_a_r;
  assign SrcB       = src_b_r;
  assign PC         = pc_r;
  assign ALUControl = ctrl_r;
  assign RspResult  = rsp_result_r;
  assign RspZero    = rsp_zero_r;
  assign Rsp0Valid  = rsp0_valid_r;
  assign Rsp1Valid  = rsp1_valid_r;

endmodule
